// File: rtl/dm_pkg.sv
// ============================================================================
// Module   : dm_pkg
// Brief    : Shared widths and FSM state type for the data-memory sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dm_pkg;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } xfer_state_t;
endpackage

`default_nettype wire

// File: rtl/dm_xfer_ctrl_if.sv
// ============================================================================
// Module   : dm_xfer_ctrl_if
// Brief    : Copy-request, core load/store and data-memory bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dm_xfer_ctrl_if;
    import dm_pkg::*;

    logic          start;
    logic [AW-1:0] src_adr;
    logic [AW-1:0] dst_adr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          core_stall;
    logic [AW-1:0] core_adr;
    logic          core_we;
    logic [DW-1:0] core_wdat;
    logic [DW-1:0] core_rdat;
    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [DW-1:0] mem_wdat;
    logic [DW-1:0] mem_rdat;

    modport slave (
        input  start, src_adr, dst_adr, len, core_adr, core_we, core_wdat, mem_rdat,
        output busy, done, core_stall, core_rdat, mem_adr, mem_we, mem_wdat
    );

    modport master (
        output start, src_adr, dst_adr, len, core_adr, core_we, core_wdat, mem_rdat,
        input  busy, done, core_stall, core_rdat, mem_adr, mem_we, mem_wdat
    );
endinterface

`default_nettype wire

// File: rtl/dm_port_mux.sv
// ============================================================================
// Module   : dm_port_mux
// Brief    : Selects core or copy-engine drive onto the data-memory port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_port_mux
    import dm_pkg::*;
(
    input  xfer_state_t   i_state,
    input  wire [AW-1:0]  i_core_adr,
    input  wire           i_core_we,
    input  wire [DW-1:0]  i_core_wdat,
    input  wire [AW-1:0]  i_src,
    input  wire [AW-1:0]  i_dst,
    input  wire [DW-1:0]  i_rd_dat,
    output logic [AW-1:0] o_mem_adr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdat
);

    always_comb begin
        o_mem_adr  = i_core_adr;
        o_mem_we   = i_core_we;
        o_mem_wdat = i_core_wdat;
        unique case (i_state)
            IDLE: ;
            RD: begin
                o_mem_adr = i_src;
                o_mem_we  = 1'b0;
            end
            // Byte fetched in RD is on the read bus now; write it straight back out.
            WR: begin
                o_mem_adr  = i_dst;
                o_mem_we   = 1'b1;
                o_mem_wdat = i_rd_dat;
            end
            DONE: begin
                o_mem_adr  = i_dst;
                o_mem_we   = 1'b0;
                o_mem_wdat = i_rd_dat;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dm_xfer_ctrl.sv
// ============================================================================
// Module   : dm_xfer_ctrl
// Brief    : Data-memory arbiter with block-copy engine that stalls the core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_xfer_ctrl
    import dm_pkg::*;
(
    input  wire           clk,
    input  wire           reset,
    dm_xfer_ctrl_if.slave bus
);

    xfer_state_t   r_state;
    xfer_state_t   w_next;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [LW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next = (bus.len == '0) ? DONE : RD;
            RD:      w_next = WR;
            WR:      w_next = (r_cnt == LW'(1)) ? DONE : RD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Addresses roll over naturally at the AW-bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src <= '0;
            r_dst <= '0;
            r_cnt <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_src <= bus.src_adr;
            r_dst <= bus.dst_adr;
            r_cnt <= bus.len;
        end else if (r_state == WR) begin
            r_src <= r_src + AW'(1);
            r_dst <= r_dst + AW'(1);
            r_cnt <= r_cnt - LW'(1);
        end
    end

    assign bus.busy       = (r_state == RD) || (r_state == WR);
    assign bus.done       = (r_state == DONE);
    assign bus.core_stall = (r_state != IDLE);
    assign bus.core_rdat  = bus.mem_rdat;

    dm_port_mux u_port_mux (
        .i_state     (r_state),
        .i_core_adr  (bus.core_adr),
        .i_core_we   (bus.core_we),
        .i_core_wdat (bus.core_wdat),
        .i_src       (r_src),
        .i_dst       (r_dst),
        .i_rd_dat    (bus.mem_rdat),
        .o_mem_adr   (bus.mem_adr),
        .o_mem_we    (bus.mem_we),
        .o_mem_wdat  (bus.mem_wdat)
    );

endmodule

`default_nettype wire

// File: tb/tb_dm_xfer_ctrl.sv
// ============================================================================
// Module   : tb_dm_xfer_ctrl
// Brief    : Directed self-checking bench for dm_xfer_ctrl with a sync-read RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dm_xfer_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   wr_cnt = 0;

    dm_xfer_ctrl_if bus ();

    dm_xfer_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] r_rdq;

    always @(posedge clk) begin
        r_rdq <= mem[bus.mem_adr];
        if (bus.mem_we) begin
            mem[bus.mem_adr] <= bus.mem_wdat;
            wr_cnt <= wr_cnt + 1;
        end
    end
    assign bus.mem_rdat = r_rdq;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic core_write(input logic [7:0] a, input logic [7:0] d);
        bus.core_adr  = a;
        bus.core_wdat = d;
        bus.core_we   = 1'b1;
        tick();
        bus.core_we   = 1'b0;
    endtask

    task automatic core_read(input logic [7:0] a, output logic [7:0] d);
        bus.core_we  = 1'b0;
        bus.core_adr = a;
        tick();
        d = bus.core_rdat;
    endtask

    // Returns cycles from the accepting edge to done, busy cycles before done,
    // and busy/stall as seen during the done cycle; ends back in IDLE.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            output int lat, output int bc, output logic busy_d,
                            output logic stall_d);
        bus.start   = 1'b1;
        bus.src_adr = s;
        bus.dst_adr = d;
        bus.len     = l;
        tick();
        bus.start = 1'b0;
        lat = 1;
        bc  = 0;
        while (!bus.done && lat < 60) begin
            if (bus.busy) bc++;
            tick();
            lat++;
        end
        busy_d  = bus.busy;
        stall_d = bus.core_stall;
        tick();
    endtask

    initial begin
        logic [7:0] rd;
        int lat, bc, w0, n, dcnt;
        logic busy_d, stall_d;

        bus.start = 1'b0; bus.src_adr = '0; bus.dst_adr = '0; bus.len = '0;
        bus.core_adr = 8'h10; bus.core_we = 1'b1; bus.core_wdat = 8'hAB;

        // Reset state and passthrough while in reset
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_stall", 32'(bus.core_stall), 32'd0);
        chk("pt_adr", 32'(bus.mem_adr), 32'h10);
        chk("pt_we", 32'(bus.mem_we), 32'd1);
        chk("pt_wdat", 32'(bus.mem_wdat), 32'hAB);
        tick();
        reset = 1'b0;
        core_read(8'h10, rd);
        chk("pt_read", 32'(rd), 32'hAB);

        // Basic copy 0x20 -> 0x40, len 4
        core_write(8'h20, 8'h11); core_write(8'h21, 8'h22);
        core_write(8'h22, 8'h33); core_write(8'h23, 8'h44);
        w0 = wr_cnt;
        run_copy(8'h20, 8'h40, 8'd4, lat, bc, busy_d, stall_d);
        chk("basic_lat", 32'(lat), 32'd9);
        chk("basic_busy_cyc", 32'(bc), 32'd8);
        chk("basic_busy_done", 32'(busy_d), 32'd0);
        chk("basic_stall_done", 32'(stall_d), 32'd1);
        chk("basic_wr_cnt", 32'(wr_cnt - w0), 32'd4);
        chk("basic_idle_stall", 32'(bus.core_stall), 32'd0);
        chk("basic_idle_done", 32'(bus.done), 32'd0);
        core_read(8'h40, rd); chk("basic_d40", 32'(rd), 32'h11);
        core_read(8'h41, rd); chk("basic_d41", 32'(rd), 32'h22);
        core_read(8'h42, rd); chk("basic_d42", 32'(rd), 32'h33);
        core_read(8'h43, rd); chk("basic_d43", 32'(rd), 32'h44);
        core_read(8'h20, rd); chk("basic_s20", 32'(rd), 32'h11);
        core_read(8'h23, rd); chk("basic_s23", 32'(rd), 32'h44);

        // Zero length
        w0 = wr_cnt;
        run_copy(8'h20, 8'h50, 8'd0, lat, bc, busy_d, stall_d);
        chk("zero_lat", 32'(lat), 32'd1);
        chk("zero_busy_cyc", 32'(bc), 32'd0);
        chk("zero_busy_done", 32'(busy_d), 32'd0);
        chk("zero_wr_cnt", 32'(wr_cnt - w0), 32'd0);

        // Address wrap-around
        core_write(8'hFE, 8'hA1); core_write(8'hFF, 8'hB2);
        core_write(8'h00, 8'hC3); core_write(8'h01, 8'hD4);
        run_copy(8'hFE, 8'h7E, 8'd4, lat, bc, busy_d, stall_d);
        chk("wrap_lat", 32'(lat), 32'd9);
        core_read(8'h7E, rd); chk("wrap_d7e", 32'(rd), 32'hA1);
        core_read(8'h7F, rd); chk("wrap_d7f", 32'(rd), 32'hB2);
        core_read(8'h80, rd); chk("wrap_d80", 32'(rd), 32'hC3);
        core_read(8'h81, rd); chk("wrap_d81", 32'(rd), 32'hD4);

        // Start together with a core write; stalled core writes and a second start
        core_write(8'h07, 8'h77);
        bus.core_adr = 8'h05; bus.core_wdat = 8'h5A; bus.core_we = 1'b1;
        bus.start = 1'b1; bus.src_adr = 8'h40; bus.dst_adr = 8'h60; bus.len = 8'd3;
        tick();
        bus.start = 1'b0;
        w0 = wr_cnt;
        bus.core_adr = 8'h07; bus.core_wdat = 8'hEE;
        n = 1; dcnt = 0; lat = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                bus.start = 1'b1; bus.src_adr = 8'h00; bus.dst_adr = 8'h07; bus.len = 8'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dcnt++;
                lat = n;
                bus.core_we = 1'b0;
            end
            tick();
            n++;
        end
        bus.core_we = 1'b0;
        chk("cont_done_cnt", 32'(dcnt), 32'd1);
        chk("cont_lat", 32'(lat), 32'd7);
        chk("cont_wr_cnt", 32'(wr_cnt - w0), 32'd3);
        core_read(8'h05, rd); chk("cont_core_wr", 32'(rd), 32'h5A);
        core_read(8'h07, rd); chk("cont_stalled_wr", 32'(rd), 32'h77);
        core_read(8'h60, rd); chk("cont_d60", 32'(rd), 32'h11);
        core_read(8'h62, rd); chk("cont_d62", 32'(rd), 32'h33);

        // Reset after the second write of a len=5 copy
        for (int i = 0; i < 5; i++) core_write(8'hA0 + 8'(i), 8'hFF);
        core_write(8'h24, 8'h55);
        bus.start = 1'b1; bus.src_adr = 8'h20; bus.dst_adr = 8'hA0; bus.len = 8'd5;
        tick();
        bus.start = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        #1;
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        chk("rmid_stall", 32'(bus.core_stall), 32'd0);
        chk("rmid_we", 32'(bus.mem_we), 32'd0);
        #2 reset = 1'b0;
        tick();
        chk("rmid_wr_cnt", 32'(wr_cnt - w0), 32'd2);
        core_read(8'hA1, rd); chk("rmid_da1", 32'(rd), 32'h22);
        core_read(8'hA2, rd); chk("rmid_da2", 32'(rd), 32'hFF);
        run_copy(8'h20, 8'hA0, 8'd5, lat, bc, busy_d, stall_d);
        chk("rmid_again_lat", 32'(lat), 32'd11);
        core_read(8'hA2, rd); chk("rmid_again_da2", 32'(rd), 32'h33);
        core_read(8'hA4, rd); chk("rmid_again_da4", 32'(rd), 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_xfer_ctrl.md
Name: dm_xfer_ctrl

Overview:
Data-memory sequencer and arbiter for the 8-bit datapath.
- Owns the single data-memory port and shares it between the core load/store path and a block-copy engine.
- On a start pulse, copies LEN bytes from SRC to DST in data memory, stalling the core until the copy completes.
- Data memory is synchronous-read: read data is valid one cycle after the address is presented.

Parameters:
- AW, 8, data-memory address width in bits.
- DW, 8, data width in bits.
- LW, 8, transfer-length width in bits (maximum 255 bytes).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_adr  in  AW  source base address; captured on accepted start.
- dst_adr  in  AW  destination base address; captured on accepted start.
- len  in  LW  byte count; captured on accepted start.
- busy  out  1  high while a copy is in progress, DONE state excluded.
- done  out  1  one-cycle pulse when a copy finishes.
- core_stall  out  1  core must hold its load/store.
- core_adr  in  AW  core memory address.
- core_we  in  1  core write enable.
- core_wdat  in  DW  core write data.
- core_rdat  out  DW  read data returned to the core (mirrors mem_rdat).
- mem_adr  out  AW  data-memory address.
- mem_we  out  1  data-memory write enable.
- mem_wdat  out  DW  data-memory write data.
- mem_rdat  in  DW  data-memory read data, valid one cycle after mem_adr.

Behaviour:
- Clock and reset: reset is asynchronous, active-high. All state registers update on the rising edge of clk.
- Reset values:
  - State is IDLE.
  - busy=0, done=0, core_stall=0.
  - Internal src, dst and count registers are 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - Memory port is combinationally passed through from the core: mem_adr=core_adr, mem_we=core_we, mem_wdat=core_wdat.
  - core_stall=0.
  - If start=1: capture src_adr, dst_adr and len.
    - len==0: go to DONE.
    - Otherwise go to RD.
  - A core access in the same cycle as start completes normally; the copy begins on the next cycle.
- RD:
  - mem_adr=src, mem_we=0, busy=1, core_stall=1.
  - Next state is WR.
- WR:
  - mem_adr=dst, mem_we=1, mem_wdat=mem_rdat (the byte read in RD), busy=1, core_stall=1.
  - Increment src and dst modulo 2^AW, so address FF wraps to 00.
  - Decrement count.
  - If the count was 1 before the decrement, go to DONE; otherwise go to RD.
- DONE:
  - done=1, busy=0, core_stall=1, mem_we=0.
  - Next state is IDLE.
  - The core is released on the following cycle.
- Timing:
  - 2 cycles per byte.
  - Total latency from the accepting edge to the done pulse is 2*len+1 cycles.
  - len==0 takes 1 cycle, straight to DONE, with no memory writes.
- Ignored inputs:
  - start while not in IDLE is ignored; it is neither queued nor restarted.
  - Core requests while core_stall=1 are not forwarded to memory. The core is responsible for holding them.
- Copy order and overlap: the copy always runs in ascending address order.
  - Overlapping regions with dst>src replicate the source pattern; this is the defined behaviour.
  - dst==src rewrites bytes unchanged.
- Reset during a copy: the block returns immediately to IDLE, and no further writes are issued. Bytes already written remain in memory.
- mem_we must never be high in RD or DONE, or in the reset state with core_we=0.

Decomposition:
- Shared package dm_pkg holds:
  - typedef enum logic[1:0] {IDLE, RD, WR, DONE} xfer_state_t;
  - constants AW, DW, LW.
- One natural sub-module: dm_port_mux.
  - Combinational selection between the core signals and the engine signals for mem_adr, mem_we and mem_wdat, keyed on state.
  - The FSM and counters stay in dm_xfer_ctrl.

Test Plan:
- Reset then idle passthrough: with core_adr=0x10, core_we=1, core_wdat=0xAB, mem_adr=0x10, mem_we=1, mem_wdat=0xAB and core_stall=0. A later core read of 0x10 returns 0xAB one cycle later.
- Basic copy: memory preloaded 0x20..0x23 = {11,22,33,44}; start with src=0x20, dst=0x40, len=4.
  - busy is high for 8 cycles, and done pulses on cycle 9.
  - 0x40..0x43 = {11,22,33,44}; the source is unchanged.
- Zero length: start with len=0 → done on the next cycle, no mem_we pulse, busy never asserted.
- Wrap-around: src=0xFE, dst=0x7E, len=4 → reads FE,FF,00,01 and writes 7E,7F,80,81 with the matching data.
- Contention: start issued in the same cycle as a core write to 0x05 → the core write lands; the copy starts next cycle.
  - A second start mid-copy is ignored, and done pulses exactly once.
  - Core writes issued while stalled never reach memory.
- Reset mid-copy: assert reset after the 2nd WR of a len=5 copy → immediately IDLE with busy=0.
  - Exactly 2 destination bytes are written.
  - A subsequent start runs normally.
